// File: rtl/note_entry_buffer.sv
// Note-entry front end: synchronizes and debounces the confirm/end-of-word buttons,
// captures the note switches on each press and queues tokens for the classifier.
module note_entry_buffer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEPTH           = 4
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [2:0] Sw_nota,
  input  logic       Sw_tom,
  input  logic       Btn_confirm,
  input  logic       Btn_fim,
  input  logic       Ack,
  output logic [2:0] Nota,
  output logic       Tom,
  output logic       Ready,
  output logic [3:0] Count,
  output logic       Full,
  output logic       Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    DEPTH_C = 4'(DEPTH);

  // Button index 0 is confirm, index 1 is end-of-word; tokens are {tom, nota}.
  logic [3:0]    sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [1:0]    btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [1:0]    deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [3:0]    mem_q [DEPTH];
  logic [3:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]    count_q, count_d;
  logic          ready_q, ready_d, full_q, full_d, ovf_q, ovf_d;
  logic [3:0]    head_q, head_d;

  logic [1:0]    press_s;
  logic          push_req_s, push_s, pop_s;
  logic [3:0]    token_s;

  // Synchronizers and per-button debounce counters.
  always_comb begin
    sw_s1_d    = {Sw_tom, Sw_nota};
    sw_s2_d    = sw_s1_q;
    btn_s1_d   = {Btn_fim, Btn_confirm};
    btn_s2_d   = btn_s1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    cnt_d      = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (btn_s2_q[i] == deb_q[i]) begin
        cnt_d[i] = {CW{1'b0}};
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = btn_s2_q[i];
        cnt_d[i] = {CW{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Press events, FIFO bookkeeping and the registered head token.
  always_comb begin
    press_s    = deb_q & ~deb_prev_q;
    push_req_s = press_s[0] | press_s[1];
    // End-of-word wins a tie, so a coincident confirm is simply absorbed.
    token_s    = press_s[1] ? 4'b0000 : sw_s2_q;
    pop_s      = ready_q & Ack;
    push_s     = push_req_s & ((count_q != DEPTH_C) | pop_s);
    mem_d      = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = token_s;
    end else begin
      mem_d = mem_q;
    end
    wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != 4'd0);
    full_d  = (count_d == DEPTH_C);
    ovf_d   = ovf_q | (push_req_s & ~push_s);
    // The new head may be the token being written this very edge.
    if (count_d == 4'd0) begin
      head_d = head_q;
    end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = token_s;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // All state, cleared asynchronously.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sw_s1_q    <= 4'b0000;
      sw_s2_q    <= 4'b0000;
      btn_s1_q   <= 2'b00;
      btn_s2_q   <= 2'b00;
      deb_q      <= 2'b00;
      deb_prev_q <= 2'b00;
      cnt_q      <= '{default: {CW{1'b0}}};
      mem_q      <= '{default: 4'b0000};
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= 4'd0;
      ready_q    <= 1'b0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      head_q     <= 4'b0000;
    end else begin
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      head_q     <= head_d;
    end
  end

  assign Nota     = head_q[2:0];
  assign Tom      = head_q[3];
  assign Ready    = ready_q;
  assign Count    = count_q;
  assign Full     = full_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_note_entry_buffer.sv
// Self-checking bench for note_entry_buffer: vector table of presses plus
// hand-written latency, bounce, overflow, full-with-pop and reset sequences.
module tb_note_entry_buffer;

  localparam int DC    = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic [2:0] Sw_nota = 3'b000;
  logic       Sw_tom = 1'b0;
  logic       Btn_confirm = 1'b0;
  logic       Btn_fim = 1'b0;
  logic       Ack = 1'b0;
  logic [2:0] Nota;
  logic       Tom;
  logic       Ready;
  logic [3:0] Count;
  logic       Full;
  logic       Overflow;

  note_entry_buffer #(.DEBOUNCE_CYCLES(DC), .DEPTH(DEPTH)) dut (
    .clk(clk), .Reset(Reset), .Sw_nota(Sw_nota), .Sw_tom(Sw_tom),
    .Btn_confirm(Btn_confirm), .Btn_fim(Btn_fim), .Ack(Ack),
    .Nota(Nota), .Tom(Tom), .Ready(Ready), .Count(Count),
    .Full(Full), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tom;
    logic [2:0] nota;
    logic       conf;
    logic       fim;
    logic [3:0] exp_tok;
    bit         drain;
  } vec_t;

  vec_t       vt [6];
  logic [3:0] sb [$];
  logic       exp_ovf;
  logic [3:0] last_tok;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge.
  task automatic do_reset(input string name);
    @(negedge clk);
    #2 Reset = 1'b0;
    #1;
    chk({name, "_count"}, {4'b0000, Count}, 8'd0);
    chk({name, "_ready"}, {7'b0, Ready}, 8'd0);
    chk({name, "_full"},  {7'b0, Full}, 8'd0);
    chk({name, "_ovf"},   {7'b0, Overflow}, 8'd0);
    chk({name, "_head"},  {4'b0000, Tom, Nota}, 8'h00);
    @(negedge clk);
    Reset = 1'b1;
    sb.delete();
    exp_ovf = 1'b0;
  endtask

  // One clean press and release; the small model decides push vs drop.
  task automatic press(input logic tom, input logic [2:0] nota, input logic conf,
                       input logic fim, input logic [3:0] exp_tok);
    @(negedge clk);
    Sw_tom = tom;
    Sw_nota = nota;
    Btn_confirm = conf;
    Btn_fim = fim;
    if (sb.size() < DEPTH) sb.push_back(exp_tok);
    else exp_ovf = 1'b1;
    repeat (DC + 4) @(negedge clk);
    Btn_confirm = 1'b0;
    Btn_fim = 1'b0;
    repeat (DC + 4) @(negedge clk);
  endtask

  // Hold Ack and compare one popped token per cycle against the scoreboard.
  task automatic drain(input string name);
    Ack = 1'b1;
    while (sb.size() > 0) begin
      chk({name, "_ready"}, {7'b0, Ready}, 8'd1);
      last_tok = sb.pop_front();
      chk({name, "_tok"}, {4'b0000, Tom, Nota}, {4'b0000, last_tok});
      @(negedge clk);
    end
    Ack = 1'b0;
    chk({name, "_empty"}, {7'b0, Ready}, 8'd0);
    chk({name, "_hold"}, {4'b0000, Tom, Nota}, {4'b0000, last_tok});
    @(negedge clk);
  endtask

  initial begin
    vt[0] = '{1'b0, 3'b100, 1'b1, 1'b0, 4'b0100, 1'b0};
    vt[1] = '{1'b0, 3'b101, 1'b1, 1'b0, 4'b0101, 1'b0};
    vt[2] = '{1'b1, 3'b111, 1'b0, 1'b1, 4'b0000, 1'b1};
    vt[3] = '{1'b1, 3'b111, 1'b1, 1'b1, 4'b0000, 1'b1};
    vt[4] = '{1'b1, 3'b000, 1'b1, 1'b0, 4'b1000, 1'b0};
    vt[5] = '{1'b1, 3'b110, 1'b1, 1'b0, 4'b1110, 1'b1};
    exp_ovf = 1'b0;
    last_tok = 4'b0000;

    do_reset("rst0");

    // Latency: push lands on edge DC+3 after the raw press.
    @(negedge clk);
    Sw_nota = 3'b011;
    Sw_tom = 1'b0;
    Btn_confirm = 1'b1;
    repeat (DC + 2) @(posedge clk);
    #1 chk("lat_early", {7'b0, Ready}, 8'd0);
    @(posedge clk);
    #1;
    chk("lat_ready", {7'b0, Ready}, 8'd1);
    chk("lat_tok",   {4'b0000, Tom, Nota}, 8'h03);
    chk("lat_count", {4'b0000, Count}, 8'd1);
    @(negedge clk);
    Btn_confirm = 1'b0;
    Ack = 1'b1;
    @(posedge clk);
    #1;
    chk("ack_ready", {7'b0, Ready}, 8'd0);
    chk("ack_count", {4'b0000, Count}, 8'd0);
    chk("ack_hold",  {4'b0000, Tom, Nota}, 8'h03);
    @(negedge clk);
    Ack = 1'b0;
    repeat (DC + 4) @(negedge clk);

    // Bounce shorter than the debounce window is ignored.
    Sw_nota = 3'b110;
    Sw_tom = 1'b1;
    for (int i = 0; i < 10; i++) begin
      Btn_confirm = ~Btn_confirm;
      repeat (2) @(negedge clk);
    end
    Btn_confirm = 1'b0;
    repeat (DC + 4) @(negedge clk);
    chk("bounce_count", {4'b0000, Count}, 8'd0);
    Btn_confirm = 1'b1;
    sb.push_back(4'b1110);
    repeat (10) @(negedge clk);
    Btn_confirm = 1'b0;
    repeat (DC + 4) @(negedge clk);
    chk("held_count", {4'b0000, Count}, 8'd1);
    drain("held");

    // Table-driven presses; drain flag closes each batch.
    for (int i = 0; i < 6; i++) begin
      press(vt[i].tom, vt[i].nota, vt[i].conf, vt[i].fim, vt[i].exp_tok);
      chk($sformatf("vec%0d_count", i), {4'b0000, Count}, 8'(sb.size()));
      if (vt[i].drain) drain($sformatf("vec%0d", i));
    end

    // Five presses into a four-entry FIFO.
    for (int i = 0; i < 5; i++) begin
      press(i[0], 3'(i + 1), 1'b1, 1'b0, {i[0], 3'(i + 1)});
    end
    chk("ovf_count", {4'b0000, Count}, 8'd4);
    chk("ovf_full",  {7'b0, Full}, 8'd1);
    chk("ovf_flag",  {7'b0, Overflow}, {7'b0, exp_ovf});
    drain("ovf");
    chk("ovf_sticky", {7'b0, Overflow}, 8'd1);

    do_reset("rst1");

    // Full FIFO: a push coinciding with a pop is accepted without overflow.
    for (int i = 0; i < 4; i++) begin
      press(1'b0, 3'(i + 4), 1'b1, 1'b0, {1'b0, 3'(i + 4)});
    end
    chk("full_count", {4'b0000, Count}, 8'd4);
    @(negedge clk);
    Sw_nota = 3'b001;
    Sw_tom = 1'b1;
    Btn_confirm = 1'b1;
    repeat (DC + 2) @(negedge clk);
    last_tok = sb.pop_front();
    chk("fp_head", {4'b0000, Tom, Nota}, {4'b0000, last_tok});
    Ack = 1'b1;
    @(negedge clk);
    Ack = 1'b0;
    sb.push_back(4'b1001);
    chk("fp_count", {4'b0000, Count}, 8'd4);
    chk("fp_full",  {7'b0, Full}, 8'd1);
    chk("fp_ovf",   {7'b0, Overflow}, 8'd0);
    Btn_confirm = 1'b0;
    repeat (DC + 4) @(negedge clk);
    drain("fp");

    // Reset with tokens queued and a press mid-debounce.
    press(1'b1, 3'b101, 1'b1, 1'b0, 4'b1101);
    press(1'b1, 3'b101, 1'b1, 1'b1, 4'b0000);
    chk("mq_count", {4'b0000, Count}, 8'd2);
    Btn_confirm = 1'b1;
    repeat (3) @(negedge clk);
    do_reset("rst2");
    repeat (DC + 2) @(posedge clk);
    #1 chk("post_rst_early", {7'b0, Ready}, 8'd0);
    @(posedge clk);
    #1;
    chk("post_rst_ready", {7'b0, Ready}, 8'd1);
    sb.push_back(4'b1101);
    @(negedge clk);
    Btn_confirm = 1'b0;
    repeat (DC + 4) @(negedge clk);
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_entry_buffer.md
Name: note_entry_buffer

Overview:
- Input stage directly upstream of the note-word classifier.
- Debounces the board's confirm and end-of-word push buttons and captures the note switches (Sw_nota, Sw_tom) on each confirmed press.
- Queues captured tokens in a small FIFO and presents them to the classifier with a Ready/Ack handshake.
- The end-of-word button enqueues the terminator token (Tom=0, Nota=3'b000), which the classifier treats as the invalid letter that closes a word.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized button level must differ from the stable level before it is accepted (≥2; the board build uses 250000).
- DEPTH, 4, FIFO entries (power of two, 2..8).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Sw_nota  input  3  note switches, asynchronous.
- Sw_tom  input  1  tone switch, asynchronous.
- Btn_confirm  input  1  raw confirm button, active-high, bouncing.
- Btn_fim  input  1  raw end-of-word button, active-high, bouncing.
- Ack  input  1  downstream consumed head token this cycle.
- Nota  output  3  head token note.
- Tom  output  1  head token tone.
- Ready  output  1  FIFO non-empty; head token valid.
- Count  output  4  entries held, 0..DEPTH.
- Full  output  1  Count == DEPTH.
- Overflow  output  1  sticky: a push was dropped.

Behaviour:
- Reset (Reset=0, asynchronous): all synchronizers, debounce counters, stable levels, pointers cleared. Count=0, Ready=0, Full=0, Overflow=0, Nota=3'b000, Tom=0.
- Synchronization: Btn_confirm, Btn_fim, Sw_nota and Sw_tom each pass through a 2-flop synchronizer. Switches must be stable ≥3 cycles before the push edge; no further qualification is applied to them.
- Debounce, per button:
  - Each button has a stable level deb and a counter cnt.
  - If the synchronized level == deb: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: deb <= synchronized level, cnt <= 0.
  - Else cnt++.
  - Bounces shorter than DEBOUNCE_CYCLES are ignored.
- Press event: deb rises 0→1, detected against the prior-cycle deb (one-cycle pulse). Release produces no event.
- Push token:
  - confirm event → {Sw_tom_sync, Sw_nota_sync}.
  - fim event → {0, 3'b000}.
  - Both in the same cycle → the terminator only is pushed; the confirm is discarded and Overflow is not set.
- Latency: raw button held high from before edge 1 → FIFO written at edge DEBOUNCE_CYCLES+3 → Ready=1 after that edge.
- Output:
  - Nota/Tom are driven from the head entry, registered.
  - While Ready=0, Nota/Tom hold the last popped values (3'b000/0 after reset).
- Pop: on an edge with Ready=1 and Ack=1. Ack while Ready=0 is ignored.
- Simultaneous push and pop:
  - Not full: both occur; Count unchanged.
  - Full: the pop frees a slot and the push is accepted, with no Overflow.
  - Empty: the push is accepted; Ack is ignored because Ready=0.
- Full, push with no pop: token dropped, FIFO unchanged, Overflow <= 1. Overflow is cleared only by reset.
- Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH. Count is a separate up/down counter.
- Reset mid-debounce or mid-transfer: partial presses are lost and all queued tokens are discarded. After Reset returns high, a held button produces a press event after DEBOUNCE_CYCLES+3 edges, because deb starts at 0.
- Token encoding: a confirm press with Sw_nota=3'b000 is pushed unchanged. Classifying it is downstream's job.

Test Plan (DEBOUNCE_CYCLES=4, DEPTH=4):
1. Sw_nota=3'b011, Sw_tom=0; Btn_confirm high and held → Ready=1 after edge 7, Nota=3'b011, Tom=0, Count=1. Ack one cycle → Ready=0, Count=0.
2. Btn_confirm toggling every 2 cycles for 20 cycles, then low → no push, Count=0. Then held high 10 cycles → exactly one push.
3. Press sequence 3'b100, 3'b101, then Btn_fim, Ack held 0 → Count=3. Then Ack=1 → Nota pops 100, 101, 000 on consecutive cycles; Ready=0 after the third pop.
4. Five confirm presses with Ack=0 → Count=4, Full=1, Overflow=1. The first four tokens are retained in order.
5. FIFO full; a confirm event coincides with Ack=1 → Count stays 4, Overflow=0, and the new token appears last.
6. Btn_confirm and Btn_fim rise together → single 000 token pushed, Count=1. Reset pulsed low mid-queue → Count=0, Ready=0, Nota=3'b000 immediately (asynchronous).
